zero_stuff_serializer: RTL and testbench

- Sequential bit-stuffing serializer that consumes a parallel data word and emits it MSB-first as a serial bit stream.
- A single 0 is inserted between every pair of adjacent 1 bits.
- Example: 5-bit word 10111 is emitted as 1010101 (7 beats); 11111 is emitted as 101010101 (9 beats).
- Sits downstream of the word source and feeds the serial line driver.
- Valid/ready handshake on both the input and output sides.

---
 rtl/zero_stuff_serializer.sv | 182 ++++++++++++++++++
 tb/tb_zero_stuff_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_stuff_serializer.sv
// zero_stuff_serializer: MSB-first serializer that inserts a single 0 between
// every pair of adjacent 1 bits of the parallel input word.
// Optional feature macro: STUFF_COUNT_EN adds a saturating 16-bit counter of
// transferred stuffed-zero beats on port stuff_count.
module zero_stuff_serializer #(
    parameter  int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
`ifdef STUFF_COUNT_EN
    ,
    output logic [15:0]      stuff_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             in_ready_q, in_ready_d;

    logic             xfer;
    logic [IDX_W-1:0] idx_m1;
    logic             cur_bit;
    logic             nxt_bit;

    assign xfer    = out_valid_q && out_ready;
    assign idx_m1  = idx_q - 1'b1;
    assign cur_bit = sh_q[idx_q];
    assign nxt_bit = sh_q[idx_m1];

    // State and registered outputs; every output resets immediately on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            idx_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state logic: the outputs for the following cycle are computed here
    // so that out_bit/out_last/out_valid come straight from flops.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        idx_d       = idx_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b1;
                if (in_valid) begin
                    sh_d        = in_data;
                    idx_d       = IDX_W'(WIDTH - 1);
                    out_bit_d   = in_data[WIDTH-1];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b0;
                    state_d     = DATA;
                end
            end

            DATA: begin
                if (xfer) begin
                    if (idx_q == '0) begin
                        out_bit_d   = 1'b0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else if (cur_bit && nxt_bit) begin
                        out_bit_d  = 1'b0;
                        out_last_d = 1'b0;
                        state_d    = STUFF;
                    end else begin
                        idx_d      = idx_m1;
                        out_bit_d  = nxt_bit;
                        out_last_d = (idx_m1 == '0);
                    end
                end
            end

            STUFF: begin
                if (xfer) begin
                    idx_d      = idx_m1;
                    out_bit_d  = nxt_bit;
                    out_last_d = (idx_m1 == '0);
                    state_d    = DATA;
                end
            end

            default: begin
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef STUFF_COUNT_EN
    logic [15:0] stuff_count_q, stuff_count_d;

    // Saturating count of stuffed zeros actually handed downstream.
    always_comb begin
        stuff_count_d = stuff_count_q;
        if (xfer && (state_q == STUFF) && (stuff_count_q != '1)) begin
            stuff_count_d = stuff_count_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_count_q <= '0;
        end else begin
            stuff_count_q <= stuff_count_d;
        end
    end

    assign stuff_count = stuff_count_q;
`endif

`ifndef SYNTHESIS
    // Input side is open only while idle.
    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        in_ready_q == (state_q == IDLE));

    // The final beat is always a data beat at bit index zero.
    a_last_data: assert property (@(posedge clk) disable iff (rst)
        out_last_q |-> (state_q == DATA) && (idx_q == '0) && out_valid_q);

    // A stuffed beat is always a valid zero.
    a_stuff_zero: assert property (@(posedge clk) disable iff (rst)
        (state_q == STUFF) |-> out_valid_q && !out_bit_q);

    // Backpressure freezes the presented beat.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=>
            out_valid_q && $stable(out_bit_q) && $stable(out_last_q));
`endif

endmodule

// File: tb/tb_zero_stuff_serializer.sv
// Scoreboard bench for zero_stuff_serializer: a driver pushes the expected
// beat sequence of each word, a monitor pops and compares transferred beats.
module tb_zero_stuff_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
`ifdef STUFF_COUNT_EN
    logic [15:0]  stuff_count;
    int unsigned  sc_exp = 0;
`endif

    zero_stuff_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef STUFF_COUNT_EN
        ,
        .stuff_count (stuff_count)
`endif
    );

    always #5 clk = ~clk;

    logic [1:0]  exp_q[$];   // {bit, last}
    int          errors = 0;
    int          checks = 0;
    int unsigned rdy_mode = 0;
    int unsigned rdy_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: MSB-first bits, a 0 between every adjacent pair of ones.
    task automatic model(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
            if (i > 0 && d[i] && d[i-1]) begin
                exp_q.push_back(2'b00);
`ifdef STUFF_COUNT_EN
                sc_exp++;
`endif
            end
        end
    endtask

    // Downstream ready generator: 0 always ready, 1 random, 2 pattern 1,0,0.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ((rdy_phase % 3) == 0);
            endcase
            rdy_phase++;
        end
    end

    // Monitor: compares every transferred beat and checks stall stability.
    initial begin
        logic       stalled;
        logic       last_seen;
        logic [1:0] held;
        logic [1:0] e;
        stalled   = 1'b0;
        last_seen = 1'b0;
        held      = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled   = 1'b0;
                last_seen = 1'b0;
            end else begin
                if (last_seen) begin
                    check("in_ready_after_last", 32'(in_ready), 32'd1);
                    check("idle_after_last", 32'(out_valid), 32'd0);
                    last_seen = 1'b0;
                end
                if (stalled) begin
                    check("stall_valid_held", 32'(out_valid), 32'd1);
                    check("stall_beat_held", 32'({out_bit, out_last}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_bit", 32'(out_bit), 32'(e[1]));
                        check("beat_last", 32'(out_last), 32'(e[0]));
                        if (out_last) last_seen = 1'b1;
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_bit, out_last};
            end
        end
    end

    // Present a word, hold it until accepted, then scramble in_data.
    task automatic send(input logic [W-1:0] d);
        int n;
        @(posedge clk);
        #2;
        in_data  = d;
        in_valid = 1'b1;
        model(d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge clk);
        check("first_beat_valid", 32'(out_valid), 32'd1);
        check("busy_not_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid)
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_count();
`ifdef STUFF_COUNT_EN
        check("stuff_count", 32'(stuff_count), 32'(sc_exp));
`endif
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'b11011;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;

        rdy_mode = 0;
        send(5'b10111);
        drain();
        check_count();

        send(5'b11111);
        send(5'b00000);
        drain();
        check_count();

        rdy_mode  = 2;
        rdy_phase = 0;
        send(5'b01101);
        drain();
        check_count();

        // Reset mid-word after the third beat of 11111.
        rdy_mode = 0;
        @(posedge clk);
        #2;
        in_data  = 5'b11111;
        in_valid = 1'b1;
        model(5'b11111);
        do @(negedge clk); while (!in_ready);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_beats_left", 32'(exp_q.size()), 32'd6);
        exp_q.delete();
`ifdef STUFF_COUNT_EN
        sc_exp = 0;
`endif
        check_count();
        repeat (2) @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;
        send(5'b10001);
        drain();
        check_count();

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            send(W'($urandom));
        end
        drain();
        check_count();

`ifdef STUFF_COUNT_EN
        rdy_mode = 0;
        force dut.stuff_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.stuff_count_q;
        sc_exp = 32'hFFFF;
        send(5'b11111);
        drain();
        check("stuff_count_saturate", 32'(stuff_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
